// File: rtl/mseq_pkg.sv
// Shared definitions for the M-sequence generator/checker family.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package mseq_pkg;

   // Default generator polynomial, x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [16:0] C_GF_COF_DEF = 17'b1_0110_1000_0000_0001;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Bit length of v: index of the highest set bit plus one.
   // A polynomial of degree W therefore returns W+1.
   function automatic int f_log2(input logic [63:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mseq_checker_if.sv
// Serial bit-stream and status bundle between a stream source and the checker.
// Latency: n/a (wires only).
// Backpressure: none; the source paces bits with EN_CK_i.
// Ports/modports:
//   master : drives EN_CK_i, DAT_i, CLR_i; observes LOCK_o, ERR_o, ERR_CNT_o, BIT_CNT_o
//   slave  : the checker side of the same signals
interface mseq_checker_if #(
   parameter int C_ERR_W = 16
);
   logic               EN_CK_i;
   logic               DAT_i;
   logic               CLR_i;
   logic               LOCK_o;
   logic               ERR_o;
   logic [C_ERR_W-1:0] ERR_CNT_o;
   logic [C_ERR_W-1:0] BIT_CNT_o;

   modport master (
      output EN_CK_i, DAT_i, CLR_i,
      input  LOCK_o, ERR_o, ERR_CNT_o, BIT_CNT_o
   );

   modport slave (
      input  EN_CK_i, DAT_i, CLR_i,
      output LOCK_o, ERR_o, ERR_CNT_o, BIT_CNT_o
   );
endinterface

// File: rtl/mseq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible one CK after the inc/clr edge.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports:
//   CK_i, XARST_i : clock, async active-low reset
//   inc, clr      : increment request, synchronous clear
//   cnt           : current count
module mseq_sat_cnt #(
   parameter int C_W = 16
) (
   input  logic           CK_i,
   input  logic           XARST_i,
   input  logic           inc,
   input  logic           clr,
   output logic [C_W-1:0] cnt
);

   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mseq_checker.sv
// Self-synchronising M-sequence checker: hunts for lock, then flywheels and counts bit errors.
// Latency: LOCK_o/ERR_o/counters update on the same CK edge that consumes the strobed bit.
// Backpressure: none; bits are consumed only on EN_CK_i, all other edges leave state untouched.
// Ports:
//   CK_i, XARST_i : clock, async active-low reset
//   bus (slave)   : EN_CK_i/DAT_i/CLR_i in; LOCK_o, ERR_o, ERR_CNT_o, BIT_CNT_o out
module mseq_checker
   import mseq_pkg::*;
#(
   parameter logic [63:0] C_GF_COF   = {47'd0, C_GF_COF_DEF},
   parameter int          C_LOCK_CNT = 32,
   parameter int          C_LOSS_WIN = 256,
   parameter int          C_LOSS_ERR = 8,
   parameter int          C_ERR_W    = 16
) (
   input  logic           CK_i,
   input  logic           XARST_i,
   mseq_checker_if.slave  bus
);

   localparam int            W      = f_log2(C_GF_COF) - 1;
   localparam logic [W-1:0]  C_TAPS = C_GF_COF[W:1];
   localparam int            FILL_W = $clog2(W + 1);
   localparam int            RUN_W  = $clog2(C_LOCK_CNT + 1);
   localparam int            WIN_W  = (C_LOSS_WIN > 1) ? $clog2(C_LOSS_WIN) : 1;
   localparam int            WERR_W = $clog2(C_LOSS_ERR + 1);

   state_t              st_q, st_d;
   logic [W-1:0]        s_q, s_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic [WERR_W-1:0]   werr_q, werr_d;
   logic                err_q, err_d;
   logic                pred;
   logic                bit_err;
   logic                err_inc;
   logic                bit_inc;
   logic [C_ERR_W-1:0]  err_cnt;
   logic [C_ERR_W-1:0]  bit_cnt;

   // Next bit the local LFSR expects, and whether the line disagrees.
   assign pred    = ^(s_q & C_TAPS);
   assign bit_err = pred ^ bus.DAT_i;

   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         st_q   <= ST_HUNT;
         s_q    <= '0;
         fill_q <= '0;
         run_q  <= '0;
         win_q  <= '0;
         werr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         s_q    <= s_d;
         fill_q <= fill_d;
         run_q  <= run_d;
         win_q  <= win_d;
         werr_q <= werr_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      s_d     = s_q;
      fill_d  = fill_q;
      run_d   = run_q;
      win_d   = win_q;
      werr_d  = werr_q;
      err_d   = 1'b0;
      err_inc = 1'b0;
      bit_inc = 1'b0;

      if (bus.EN_CK_i) begin
         if (st_q == ST_HUNT) begin
            // While hunting the register is loaded straight from the line.
            s_d = {s_q[W-2:0], bus.DAT_i};
            if (fill_q != FILL_W'(W)) begin
               fill_d = fill_q + 1'b1;
            end else if ((s_q == '0) || bit_err) begin
               // An all-zero register predicts zeros forever; never let it build a run.
               run_d = '0;
            end else begin
               run_d = run_q + 1'b1;
            end
            if (run_d == RUN_W'(C_LOCK_CNT)) begin
               st_d   = ST_LOCK;
               win_d  = '0;
               werr_d = '0;
            end
         end else begin
            // Flywheel: feed back the prediction so line errors do not pollute the state.
            s_d     = {s_q[W-2:0], pred};
            bit_inc = 1'b1;
            if (bit_err) begin
               err_d   = 1'b1;
               err_inc = 1'b1;
               werr_d  = werr_q + 1'b1;
            end
            if (werr_d == WERR_W'(C_LOSS_ERR)) begin
               st_d   = ST_HUNT;
               fill_d = '0;
               run_d  = '0;
            end else if (win_q == WIN_W'(C_LOSS_WIN - 1)) begin
               // Window closes after this bit has been counted into it.
               win_d  = '0;
               werr_d = '0;
            end else begin
               win_d = win_q + 1'b1;
            end
         end
      end
   end

   mseq_sat_cnt #(.C_W(C_ERR_W)) u_err_cnt (
      .CK_i    (CK_i),
      .XARST_i (XARST_i),
      .inc     (err_inc),
      .clr     (bus.CLR_i),
      .cnt     (err_cnt)
   );

   mseq_sat_cnt #(.C_W(C_ERR_W)) u_bit_cnt (
      .CK_i    (CK_i),
      .XARST_i (XARST_i),
      .inc     (bit_inc),
      .clr     (bus.CLR_i),
      .cnt     (bit_cnt)
   );

   assign bus.LOCK_o    = (st_q == ST_LOCK);
   assign bus.ERR_o     = err_q;
   assign bus.ERR_CNT_o = err_cnt;
   assign bus.BIT_CNT_o = bit_cnt;

endmodule
